dither_stream_engine: RTL and testbench
=======================================

# dither_stream_engine

Streaming, parametrised Floyd-Steinberg error-diffusion engine. It replaces frame-resident SRAM dithering with a one-row error line buffer per channel. It accepts raster-order pixels from the SPI ingest path over a valid/ready stream and emits quantised pixels over a second valid/ready stream. It supports N channels, arbitrary input bit depth, 1..RGB_SIZE output bits per channel, and a threshold-only bypass mode.

## Interface
- IMAGEX, 64, pixels per row (≥2)
- IMAGEY, 64, rows per frame (≥1)
- RGB_SIZE, 8, input bits per channel
- OUT_BITS, 1, output bits per channel (1..RGB_SIZE)
- CHANNELS, 1, parallel colour channels (1..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; begins a frame from IDLE, ignored elsewhere
- diffuse_en  in  1  1 = Floyd-Steinberg, 0 = plain quantise; sampled on start
- s_valid  in  1  input pixel valid
- s_ready  out  1  engine accepts pixel
- s_data  in  CHANNELS*RGB_SIZE  pixel, channel 0 in LSBs
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts
- m_data  out  CHANNELS*OUT_BITS  quantised pixel
- m_last  out  1  qualifies the final pixel of the frame
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after the last output handshake

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start.
  - RUN→FLUSH on acceptance of pixel x=IMAGEX-1.
  - FLUSH→RUN (1 cycle) if more rows remain, else FLUSH→DONE.
  - DONE→IDLE once m_valid=0; frame_done pulses on that transition.
- Counters x (0..IMAGEX-1) and y (0..IMAGEY-1) advance per accepted pixel. x wraps to 0 at row end; y wraps after the last row.
- Per channel c, all error values are held signed in sixteenths, width RGB_SIZE+6.
  - buf[IMAGEX]: next-row accumulators.
  - carry_e: east contribution.
  - win0, win1: partial next-row sums for x-1 and x.
- Corrected value: v = in + ((rowacc + carry_e) >>> 4), arithmetic (floor) shift. rowacc = buf[x] if y>0, else 0. Clamp v to [0, 2^RGB_SIZE-1].
- Quantise: q = (v*(2^OUT_BITS-1) + 2^(RGB_SIZE-1)) >> RGB_SIZE.
- Reconstruct: recon = q bit-replicated to RGB_SIZE bits. For 1 bit at 8 bits: 0 or 255.
- Error: e = v - recon (signed, |e| ≤ 2^(RGB_SIZE-1)).
- On accept at column x:
  - If x>0: buf[x-1] ← win0 + 3e.
  - win0 ← win1 + 5e.
  - win1 ← e.
  - carry_e ← 7e, or 0 if x=IMAGEX-1.
- In FLUSH, buf[IMAGEX-1] ← win0; then win0, win1, carry_e ← 0.
- Boundaries:
  - x=0: the SW share is discarded.
  - x=IMAGEX-1: the E and SE shares are discarded.
  - Last row: buf writes are suppressed.
  - Contributions never wrap across rows or frames.
- diffuse_en=0: e is forced to 0, so the output is pure rounding quantisation.
- buf uses asynchronous-read register/LUT storage, with no read latency.

## Timing
- Reset values:
  - state=IDLE; s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0.
  - Counters, window registers and carry_e = 0. buf contents are don't-care because row 0 ignores buf.
- s_ready = (state==RUN) && (!m_valid || m_ready).
- A transfer occurs when s_valid && s_ready.
- Latency: 1 cycle. The pixel accepted at edge n has m_data valid after edge n.
- m_data and m_last are held stable while m_valid && !m_ready.
- FLUSH costs exactly 1 cycle of s_ready=0 per row. Throughput is IMAGEX/(IMAGEX+1) pixels per cycle.
- A start pulse while busy is ignored. diffuse_en changes mid-frame have no effect.
- rst_n low mid-frame aborts immediately to the reset values; the partial frame is lost and no frame_done pulse is issued.

## Test plan
- IMAGEX=4, IMAGEY=2, OUT_BITS=1, diffuse_en=1, all inputs 128 -> first two outputs 1, 0 (pixel 1: 128 + floor(-889/16) = 72 -> 0); m_last only on the 8th output; frame_done 1 cycle later.
- diffuse_en=0, inputs 127 and 128 -> outputs 0 and 1. OUT_BITS=2, input 85 -> q=1; input 42 -> 0; input 43 -> 1.
- IMAGEX=4, IMAGEY=2, 1 bit, zeros except (3,0)=120 and (3,1)=90 -> (3,1) outputs 1 (90 + floor(754/16) = 137); all other outputs 0; no contribution reaches (0,1).
- All inputs 255, CHANNELS=3 -> every output 3'b111 and internal error stays 0; the clamp is exercised with input 250 after a +16 carry -> v=255, not overflow.
- m_ready held low 5 cycles mid-row -> s_ready=0, m_data stable, no pixel lost or duplicated; compare against a reference model.
- rst_n asserted at pixel 5, then a new start -> outputs match a clean run of the new frame; no stale error from the aborted frame.

Source files
------------

// File: rtl/dither_stream_engine.sv
// -----------------------------------------------------------------------------
// dither_stream_engine
//
// Streaming Floyd-Steinberg error-diffusion quantiser. Raster-order pixels come
// in on a valid/ready stream, quantised pixels leave on a second valid/ready
// stream one cycle later. Each channel keeps a single row of next-row error
// accumulators plus a small sliding window, so no frame storage is needed.
// With diffusion disabled the engine performs plain rounding quantisation.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a frame when idle (ignored otherwise)
//   diffuse_en  1 = error diffusion, 0 = plain quantise; sampled on start
//   s_valid     input pixel valid
//   s_ready     engine can accept a pixel this cycle
//   s_data      input pixel, CHANNELS x RGB_SIZE bits, channel 0 in LSBs
//   m_valid     output pixel valid
//   m_ready     downstream accepts the output pixel
//   m_data      quantised pixel, CHANNELS x OUT_BITS bits, channel 0 in LSBs
//   m_last      marks the final pixel of the frame
//   busy        engine is not idle
//   frame_done  one-cycle pulse once the last output has been taken
// -----------------------------------------------------------------------------
module dither_stream_engine #(
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int RGB_SIZE = 8,
  parameter int OUT_BITS = 1,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         diffuse_en,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*RGB_SIZE-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*OUT_BITS-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         frame_done
);

  // Error values are signed sixteenths; six extra bits cover sign plus the
  // worst-case sum of all four neighbour shares.
  localparam int EW = RGB_SIZE + 6;
  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int PW = RGB_SIZE + OUT_BITS + 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGEY - 1);

  localparam logic [PW-1:0] OUT_MAX = PW'((1 << OUT_BITS) - 1);
  localparam logic [PW-1:0] HALF    = PW'(1 << (RGB_SIZE - 1));

  localparam logic signed [EW-1:0] K3 = EW'(3);
  localparam logic signed [EW-1:0] K5 = EW'(5);
  localparam logic signed [EW-1:0] K7 = EW'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                       state_q;
  logic [XW-1:0]                x_q;
  logic [YW-1:0]                y_q;
  logic                         last_row_q;
  logic                         diffuse_q;
  logic                         m_valid_q;
  logic                         m_last_q;
  logic                         frame_done_q;
  logic [CHANNELS*OUT_BITS-1:0] m_data_q;
  logic [CHANNELS*OUT_BITS-1:0] q_all_d;

  logic accept;
  logic row_end;
  logic on_last_row;
  logic flush;

  assign s_ready     = (state_q == S_RUN) && (!m_valid_q || m_ready);
  assign accept      = s_valid && s_ready;
  assign row_end     = (x_q == X_LAST);
  assign on_last_row = (y_q == Y_LAST);
  assign flush       = (state_q == S_FLUSH);

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  // ---------------------------------------------------------------------------
  // Per-channel datapath: correction, clamp, quantise, error and diffusion.
  // ---------------------------------------------------------------------------
  genvar gi, gb;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [EW-1:0] carry_q;
      logic signed [EW-1:0] win0_q;
      logic signed [EW-1:0] win1_q;
      logic signed [EW-1:0] line_q [IMAGEX];

      logic signed [EW-1:0] rowacc_d;
      logic signed [EW-1:0] sum_d;
      logic signed [EW-1:0] v_raw_d;
      logic signed [EW-1:0] err_d;
      logic [RGB_SIZE-1:0]  pix_d;
      logic [RGB_SIZE-1:0]  v_d;
      logic [RGB_SIZE-1:0]  recon_d;
      logic [PW-1:0]        prod_d;
      logic [OUT_BITS-1:0]  q_d;

      assign pix_d = s_data[gi*RGB_SIZE +: RGB_SIZE];

      // Row 0 never reads the line buffer, so its contents after reset or an
      // aborted frame cannot leak into a new frame.
      assign rowacc_d = (y_q != '0) ? line_q[x_q] : '0;
      assign sum_d    = rowacc_d + carry_q;
      assign v_raw_d  = $signed({{(EW-RGB_SIZE){1'b0}}, pix_d}) + (sum_d >>> 4);

      always_comb begin
        v_d = v_raw_d[RGB_SIZE-1:0];
        if (v_raw_d[EW-1]) begin
          v_d = '0;
        end else if (|v_raw_d[EW-2:RGB_SIZE]) begin
          v_d = '1;
        end
      end

      assign prod_d = PW'(v_d) * OUT_MAX + HALF;
      assign q_d    = OUT_BITS'(prod_d >> RGB_SIZE);

      // Reconstruction repeats the output code from the MSB down.
      for (gb = 0; gb < RGB_SIZE; gb++) begin : g_rep
        assign recon_d[RGB_SIZE-1-gb] = q_d[OUT_BITS-1-(gb % OUT_BITS)];
      end

      assign err_d = diffuse_q
                   ? ($signed({{(EW-RGB_SIZE){1'b0}}, v_d})
                      - $signed({{(EW-RGB_SIZE){1'b0}}, recon_d}))
                   : '0;

      assign q_all_d[gi*OUT_BITS +: OUT_BITS] = q_d;

      // win1 holds the SE share for the next column, win0 the partial
      // next-row sum for the current column awaiting its SW share.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_q <= '0;
          win0_q  <= '0;
          win1_q  <= '0;
        end else if (accept) begin
          win0_q  <= win1_q + K5 * err_d;
          win1_q  <= err_d;
          carry_q <= row_end ? '0 : K7 * err_d;
        end else if (flush) begin
          carry_q <= '0;
          win0_q  <= '0;
          win1_q  <= '0;
        end
      end

      // Column x-1 is complete once x contributes its SW share; the final
      // column is closed out in the flush cycle.
      always_ff @(posedge clk) begin
        if (accept && (x_q != '0) && !on_last_row) begin
          line_q[x_q - XW'(1)] <= win0_q + K3 * err_d;
        end else if (flush && !last_row_q) begin
          line_q[IMAGEX-1] <= win0_q;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM and output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      last_row_q   <= 1'b0;
      diffuse_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= q_all_d;
        m_last_q  <= row_end && on_last_row;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            diffuse_q <= diffuse_en;
            x_q       <= '0;
            y_q       <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (row_end) begin
              x_q        <= '0;
              last_row_q <= on_last_row;
              y_q        <= on_last_row ? '0 : y_q + YW'(1);
              state_q    <= S_FLUSH;
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        S_FLUSH: begin
          state_q <= last_row_q ? S_DONE : S_RUN;
        end
        S_DONE: begin
          if (!m_valid_q) begin
            state_q      <= S_IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dither_stream_engine.sv
module tb_dither_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start1, start2, diffuse_en, s_valid, m_ready;
  logic [23:0] s_data;

  logic       s_ready1, m_valid1, m_last1, busy1, fd1;
  logic [2:0] m_data1;
  logic       s_ready2, m_valid2, m_last2, busy2, fd2;
  logic [3:0] m_data2;

  // dut: 4x2 frame, 1 output bit, 3 channels
  dither_stream_engine #(.IMAGEX(4), .IMAGEY(2), .RGB_SIZE(8), .OUT_BITS(1), .CHANNELS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .diffuse_en(diffuse_en),
    .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
    .busy(busy1), .frame_done(fd1)
  );

  // dut2: 5x3 frame, 2 output bits, 2 channels
  dither_stream_engine #(.IMAGEX(5), .IMAGEY(3), .RGB_SIZE(8), .OUT_BITS(2), .CHANNELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .diffuse_en(diffuse_en),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data[15:0]),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
    .busy(busy2), .frame_done(fd2)
  );

  bit         sel;
  logic       s_ready_s, m_valid_s, m_last_s, busy_s, fd_s;
  logic [3:0] m_data_s;

  always_comb begin
    s_ready_s = sel ? s_ready2 : s_ready1;
    m_valid_s = sel ? m_valid2 : m_valid1;
    m_last_s  = sel ? m_last2  : m_last1;
    busy_s    = sel ? busy2    : busy1;
    fd_s      = sel ? fd2      : fd1;
    m_data_s  = sel ? m_data2  : {1'b0, m_data1};
  end

  int W, H, OB, CH;
  int pix [3][8][8];
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  bit         gotlast_q[$];
  int hold_viol, sready_viol, fd_early, fd_len, stall_cnt;
  logic [8:0] ab_vec;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic use_dut(input bit s);
    sel = s;
    if (!s) begin W = 4; H = 2; OB = 1; CH = 3; end
    else    begin W = 5; H = 3; OB = 2; CH = 2; end
  endtask

  task automatic fill_random();
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) pix[c][y][x] = int'($urandom_range(255));
  endtask

  task automatic fill_const(input int val);
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) pix[c][y][x] = val;
  endtask

  // Reference: whole-frame error image; each pixel pushes its error to the
  // four Floyd-Steinberg neighbours that lie inside the frame.
  function automatic void build_expected(input bit dif);
    int acc [3][8][8];
    int v, q, recon, e, omax, word;
    omax = (1 << OB) - 1;
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) acc[c][y][x] = 0;
    exp_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        word = 0;
        for (int c = 0; c < CH; c++) begin
          v = pix[c][y][x] + (acc[c][y][x] >>> 4);
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          q = (v * omax + 128) >> 8;
          recon = q * 255 / omax;
          e = dif ? (v - recon) : 0;
          if (x + 1 < W) acc[c][y][x+1] += 7 * e;
          if (y + 1 < H) begin
            if (x > 0) acc[c][y+1][x-1] += 3 * e;
            acc[c][y+1][x] += 5 * e;
            if (x + 1 < W) acc[c][y+1][x+1] += e;
          end
          word = word | (q << (c * OB));
        end
        exp_q.push_back(4'(word));
      end
    end
  endfunction

  function automatic logic [23:0] pack(input int idx);
    logic [23:0] d;
    d = '0;
    for (int c = 0; c < CH; c++) d[c*8 +: 8] = 8'(pix[c][idx / W][idx % W]);
    return d;
  endfunction

  // Drives one frame into the selected engine and records what comes out.
  task automatic run_frame(input bit dif, input bit rnd, input bit stall, input int abort_at);
    int n, in_idx, out_idx, cyc;
    bit prev_hold, prev_last;
    logic [3:0] prev_data;
    n = W * H;
    got_q.delete(); gotlast_q.delete();
    hold_viol = 0; sready_viol = 0; fd_early = 0; fd_len = 0; stall_cnt = 0;
    @(negedge clk);
    diffuse_en = dif;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    diffuse_en = ~dif;
    in_idx = 0; out_idx = 0; cyc = 0; prev_hold = 0; prev_data = '0; prev_last = 0;
    while (out_idx < n && cyc < 3000) begin
      s_valid = (in_idx < n) && (!rnd || $urandom_range(3) != 0);
      s_data  = (in_idx < n) ? pack(in_idx) : '0;
      m_ready = !rnd || $urandom_range(3) != 0;
      if (stall && out_idx >= 2 && stall_cnt < 5 && m_valid_s) begin
        m_ready = 1'b0;
        stall_cnt++;
      end
      start1 = 1'b0; start2 = 1'b0;
      if (cyc == 3) begin
        if (sel) start2 = 1'b1; else start1 = 1'b1;
      end
      #1;
      if (prev_hold && (!m_valid_s || m_data_s !== prev_data || m_last_s !== prev_last)) hold_viol++;
      if (m_valid_s && !m_ready && s_ready_s) sready_viol++;
      if (fd_s) fd_early++;
      if (s_valid && s_ready_s) in_idx++;
      if (m_valid_s && m_ready) begin
        got_q.push_back(m_data_s);
        gotlast_q.push_back(m_last_s);
        out_idx++;
      end
      prev_hold = m_valid_s && !m_ready;
      prev_data = m_data_s;
      prev_last = m_last_s;
      cyc++;
      if (abort_at >= 0 && in_idx >= abort_at) break;
      @(negedge clk);
    end
    start1 = 1'b0; start2 = 1'b0;
    if (abort_at >= 0) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      ab_vec = {s_ready_s, m_valid_s, m_data_s, m_last_s, busy_s, fd_s};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      s_valid = 1'b0;
      repeat (4) begin
        @(negedge clk); #1;
        if (fd_s) fd_early++;
      end
      return;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (fd_s) fd_len++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 0; start2 = 0; s_valid = 0; m_ready = 0; diffuse_en = 0; s_data = '0;
    use_dut(0);
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({s_ready1, m_valid1, m_data1, m_last1, busy1, fd1} !== 8'h00)
      $display("FAIL reset_dut: got %b required 00000000", {s_ready1, m_valid1, m_data1, m_last1, busy1, fd1});
    else pass_cnt++;
    total_cnt++;
    if ({s_ready2, m_valid2, m_data2, m_last2, busy2, fd2} !== 9'h000)
      $display("FAIL reset_dut2: got %b required 000000000", {s_ready2, m_valid2, m_data2, m_last2, busy2, fd2});
    else pass_cnt++;
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({busy1, s_ready1} !== 2'b00) $display("FAIL idle_no_start: got %b required 00", {busy1, s_ready1});
    else pass_cnt++;
  endtask

  task automatic test_diffuse_flat();
    use_dut(0);
    fill_const(128);
    build_expected(1);
    run_frame(1, 0, 0, -1);
    total_cnt++;
    if (got_q.size() !== 8) $display("FAIL flat_count: got %0d required 8", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || gotlast_q[i] !== (i == 7))
        $display("FAIL flat_px%0d: got %h/%0b required %h/%0b", i, (i < got_q.size()) ? got_q[i] : 4'hx,
                 (i < got_q.size()) ? gotlast_q[i] : 1'b0, exp_q[i], (i == 7));
      else begin pass_cnt++; $display("flat px%0d data %h last %0b", i, got_q[i], gotlast_q[i]); end
    end
    total_cnt++;
    if (got_q.size() < 2 || got_q[0] !== 4'h7 || got_q[1] !== 4'h0)
      $display("FAIL flat_first_two: got %h %h required 7 0", (got_q.size() > 0) ? got_q[0] : 4'hx, (got_q.size() > 1) ? got_q[1] : 4'hx);
    else pass_cnt++;
    total_cnt++;
    if (fd_len !== 1 || fd_early !== 0)
      $display("FAIL flat_frame_done: got len %0d early %0d required 1 0", fd_len, fd_early);
    else pass_cnt++;
  endtask

  task automatic test_quantise();
    use_dut(0);
    fill_random();
    for (int c = 0; c < 3; c++) begin pix[c][0][0] = 127; pix[c][0][1] = 128; end
    build_expected(0);
    run_frame(0, 1, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL quant1_px%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      else begin pass_cnt++; $display("quant1 px%0d data %h", i, got_q[i]); end
    end
    total_cnt++;
    if (got_q.size() < 2 || got_q[0] !== 4'h0 || got_q[1] !== 4'h7)
      $display("FAIL quant_127_128: got %h %h required 0 7", (got_q.size() > 0) ? got_q[0] : 4'hx, (got_q.size() > 1) ? got_q[1] : 4'hx);
    else pass_cnt++;

    use_dut(1);
    fill_random();
    pix[0][0][0] = 85; pix[0][0][1] = 42; pix[0][0][2] = 43;
    build_expected(0);
    run_frame(0, 1, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL quant2_px%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      else begin pass_cnt++; $display("quant2 px%0d data %h", i, got_q[i]); end
    end
    total_cnt++;
    if (got_q.size() < 3 || got_q[0][1:0] !== 2'd1 || got_q[1][1:0] !== 2'd0 || got_q[2][1:0] !== 2'd1)
      $display("FAIL quant2_85_42_43: got %h %h %h (ch0 low bits) required 1 0 1",
               (got_q.size() > 0) ? got_q[0] : 4'hx, (got_q.size() > 1) ? got_q[1] : 4'hx, (got_q.size() > 2) ? got_q[2] : 4'hx);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    use_dut(0);
    fill_const(0);
    for (int c = 0; c < 3; c++) begin pix[c][0][3] = 120; pix[c][1][3] = 90; end
    build_expected(1);
    run_frame(1, 1, 0, -1);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== ((i == 7) ? 4'h7 : 4'h0) || got_q[i] !== exp_q[i])
        $display("FAIL edge_px%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, (i == 7) ? 4'h7 : 4'h0);
      else begin pass_cnt++; $display("edge px%0d data %h", i, got_q[i]); end
    end
  endtask

  task automatic test_clamp();
    use_dut(0);
    fill_const(255);
    build_expected(1);
    run_frame(1, 0, 0, -1);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== 4'h7)
        $display("FAIL sat_px%0d: got %h required 7", i, (i < got_q.size()) ? got_q[i] : 4'hx);
      else begin pass_cnt++; $display("sat px%0d data %h", i, got_q[i]); end
    end
    fill_const(0);
    for (int c = 0; c < 3; c++) begin pix[c][0][0] = 37; pix[c][0][1] = 250; end
    build_expected(1);
    run_frame(1, 0, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL clamp_px%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      else begin pass_cnt++; $display("clamp px%0d data %h", i, got_q[i]); end
    end
    total_cnt++;
    if (got_q.size() < 2 || got_q[1] !== 4'h7)
      $display("FAIL clamp_250: got %h required 7", (got_q.size() > 1) ? got_q[1] : 4'hx);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    for (int d = 0; d < 2; d++) begin
      use_dut(d[0]);
      fill_random();
      build_expected(1);
      run_frame(1, d[0], 1, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        total_cnt++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i] || gotlast_q[i] !== (i == W * H - 1))
          $display("FAIL bp%0d_px%0d: got %h required %h", d, i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
        else begin pass_cnt++; $display("bp%0d px%0d data %h", d, i, got_q[i]); end
      end
      total_cnt++;
      if (hold_viol !== 0 || sready_viol !== 0 || stall_cnt !== 5)
        $display("FAIL bp%0d_stall: got hold %0d sready %0d stall %0d required 0 0 5", d, hold_viol, sready_viol, stall_cnt);
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() !== W * H || fd_len !== 1)
        $display("FAIL bp%0d_count: got %0d outputs, frame_done %0d required %0d, 1", d, got_q.size(), fd_len, W * H);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    use_dut(0);
    fill_random();
    build_expected(1);
    run_frame(1, 1, 0, 5);
    total_cnt++;
    if (ab_vec !== 9'h000 || fd_early !== 0)
      $display("FAIL abort_state: got %b frame_done %0d required 000000000 0", ab_vec, fd_early);
    else pass_cnt++;
    fill_random();
    build_expected(1);
    run_frame(1, 1, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL abort_px%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
      else begin pass_cnt++; $display("abort px%0d data %h", i, got_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    use_dut(1);
    for (int f = 0; f < 2; f++) begin
      fill_random();
      build_expected(1);
      run_frame(1, 1, 0, -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        total_cnt++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i] || gotlast_q[i] !== (i == W * H - 1))
          $display("FAIL b2b%0d_px%0d: got %h required %h", f, i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_q[i]);
        else begin pass_cnt++; $display("b2b%0d px%0d data %h", f, i, got_q[i]); end
      end
      total_cnt++;
      if (fd_len !== 1 || busy_s !== 1'b0)
        $display("FAIL b2b%0d_done: got frame_done %0d busy %0b required 1 0", f, fd_len, busy_s);
      else pass_cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_diffuse_flat();
    test_quantise();
    test_boundary();
    test_clamp();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
